// File: rtl/hall_call_manager.sv
`default_nettype none
// ============================================================================
// hall_call_manager: latches hall calls, lights acknowledge lamps, offers
// pending calls to the dispatcher. Optional macro: HALL_CALL_REDISPATCH_EN.
// Revision: 1.0
// ============================================================================
module hall_call_manager #(
  parameter int NUM_FLOORS        = 7,
  parameter int FLOOR_W           = 3,
  parameter int REDISPATCH_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] hall_req_up,
  input  logic [NUM_FLOORS-1:0] hall_req_down,
  output logic [NUM_FLOORS-1:0] lamp_up,
  output logic [NUM_FLOORS-1:0] lamp_down,
  output logic                  dispatch_valid,
  output logic [FLOOR_W-1:0]    dispatch_floor,
  output logic                  dispatch_up_ndown,
  input  logic                  dispatch_ready,
  input  logic                  car_arrived,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  car_dir_up_ndown
);

  localparam int NSLOT  = 2 * NUM_FLOORS;
  localparam int SLOT_W = $clog2(NSLOT);

  localparam logic [0:0] S_SEARCH = 1'b0;
  localparam logic [0:0] S_OFFER  = 1'b1;

  logic [NSLOT-1:0]   pending_q, pending_d;
  logic [NSLOT-1:0]   disp_q, disp_d;
  logic [SLOT_W-1:0]  ptr_q, ptr_d;
  logic [SLOT_W-1:0]  off_slot_q, off_slot_d;
  logic [0:0]         state_q, state_d;
  logic               valid_q, valid_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               dir_q, dir_d;

  logic [NSLOT-1:0]   w_slot_ok, w_set, w_clr, w_elig;
  logic               w_hs, w_found, w_redisp_wrap;
  logic [SLOT_W-1:0]  w_sel;
  logic [SLOT_W:0]    w_idx;

  if ((1 << FLOOR_W) < NUM_FLOORS || REDISPATCH_CYCLES < 2) begin : g_cfg_check
    $error("hall_call_manager: invalid parameter combination");
  end

  // Slot 2f+1 is up at floor f, slot 2f is down; top-up and bottom-down never exist.
  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_slot
    assign w_slot_ok[2*f+1] = (f < NUM_FLOORS - 1);
    assign w_slot_ok[2*f]   = (f > 0);
    assign w_set[2*f+1]     = hall_req_up[f];
    assign w_set[2*f]       = hall_req_down[f];
    assign w_clr[2*f+1]     = car_arrived && (car_floor == FLOOR_W'(f)) && car_dir_up_ndown;
    assign w_clr[2*f]       = car_arrived && (car_floor == FLOOR_W'(f)) && !car_dir_up_ndown;
    assign lamp_up[f]       = pending_q[2*f+1];
    assign lamp_down[f]     = pending_q[2*f];
  end

`ifdef HALL_CALL_REDISPATCH_EN
  localparam int CNT_W = $clog2(REDISPATCH_CYCLES);
  logic [CNT_W-1:0] cnt_q;

  assign w_redisp_wrap = (cnt_q == CNT_W'(REDISPATCH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || w_redisp_wrap) cnt_q <= '0;
    else                        cnt_q <= cnt_q + 1'b1;
  end
`else
  assign w_redisp_wrap = 1'b0;
`endif

  assign w_hs      = valid_q && dispatch_ready;
  assign w_elig    = pending_q & ~disp_q & ~w_clr;
  assign pending_d = (pending_q | (w_set & w_slot_ok)) & ~w_clr;

  // Round-robin scan starting at the pointer; first eligible slot wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < NSLOT; i++) begin
      w_idx = {1'b0, ptr_q} + (SLOT_W+1)'(i);
      if (w_idx >= (SLOT_W+1)'(NSLOT)) w_idx = w_idx - (SLOT_W+1)'(NSLOT);
      if (!w_found && w_elig[w_idx[SLOT_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[SLOT_W-1:0];
      end
    end
  end

  always_comb begin
    disp_d = disp_q;
    if (w_redisp_wrap) disp_d = disp_d & ~pending_q;
    if (w_hs)          disp_d[off_slot_q] = 1'b1;
    disp_d = disp_d & ~w_clr;
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    off_slot_d = off_slot_q;
    ptr_d      = ptr_q;
    case (state_q)
      S_SEARCH: begin
        if (w_found) begin
          state_d    = S_OFFER;
          valid_d    = 1'b1;
          floor_d    = FLOOR_W'(w_sel >> 1);
          dir_d      = w_sel[0];
          off_slot_d = w_sel;
        end
      end
      S_OFFER: begin
        if (w_hs) begin
          state_d = S_SEARCH;
          valid_d = 1'b0;
          ptr_d   = (off_slot_q == SLOT_W'(NSLOT - 1)) ? '0 : off_slot_q + 1'b1;
        end else if (w_clr[off_slot_q]) begin
          // Call served by a car before the dispatcher took it: withdraw.
          state_d = S_SEARCH;
          valid_d = 1'b0;
        end
      end
      default: state_d = S_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      disp_q     <= '0;
      ptr_q      <= '0;
      off_slot_q <= '0;
      state_q    <= S_SEARCH;
      valid_q    <= 1'b0;
      floor_q    <= '0;
      dir_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      disp_q     <= disp_d;
      ptr_q      <= ptr_d;
      off_slot_q <= off_slot_d;
      state_q    <= state_d;
      valid_q    <= valid_d;
      floor_q    <= floor_d;
      dir_q      <= dir_d;
    end
  end

  assign dispatch_valid    = valid_q;
  assign dispatch_floor    = floor_q;
  assign dispatch_up_ndown = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_hall_call_manager.sv
`default_nettype none
// ============================================================================
// tb_hall_call_manager: directed scenarios plus randomized traffic checked
// against a floor/direction level reference model.
// Revision: 1.0
// ============================================================================
module tb_hall_call_manager;

  localparam int NF = 7;
  localparam int FW = 3;
  localparam int RC = 16;

  logic          clk;
  logic          reset;
  logic [NF-1:0] hall_req_up, hall_req_down, lamp_up, lamp_down;
  logic          dispatch_valid, dispatch_up_ndown, dispatch_ready;
  logic [FW-1:0] dispatch_floor, car_floor;
  logic          car_arrived, car_dir_up_ndown;

  int n_assert = 0;
  int n_fail   = 0;

  hall_call_manager #(.NUM_FLOORS(NF), .FLOOR_W(FW), .REDISPATCH_CYCLES(RC)) dut (
    .clk              (clk),
    .reset            (reset),
    .hall_req_up      (hall_req_up),
    .hall_req_down    (hall_req_down),
    .lamp_up          (lamp_up),
    .lamp_down        (lamp_down),
    .dispatch_valid   (dispatch_valid),
    .dispatch_floor   (dispatch_floor),
    .dispatch_up_ndown(dispatch_up_ndown),
    .dispatch_ready   (dispatch_ready),
    .car_arrived      (car_arrived),
    .car_floor        (car_floor),
    .car_dir_up_ndown (car_dir_up_ndown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: calls as [floor][dir], offer as (floor, dir), pointer as an int.
  bit m_pend [NF][2];
  bit m_disp [NF][2];
  int m_ptr, m_floor, m_sel, m_cf, m_cd;
  bit m_valid, m_up, m_found, m_clr, m_hs;
  int m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      foreach (m_pend[f, d]) begin m_pend[f][d] = 0; m_disp[f][d] = 0; end
      m_ptr = 0; m_valid = 0; m_floor = 0; m_up = 0; m_cnt = 0;
    end else begin
      m_cf  = int'(car_floor);
      m_cd  = int'(car_dir_up_ndown);
      m_clr = car_arrived && (m_cf < NF);
      m_hs  = m_valid && dispatch_ready;
      m_found = 0;
      m_sel   = 0;
      if (!m_valid) begin
        for (int k = 0; k < 2 * NF; k++) begin
          int s, f, d;
          s = (m_ptr + k) % (2 * NF);
          f = s / 2;
          d = s % 2;
          if (!m_found && m_pend[f][d] && !m_disp[f][d] && !(m_clr && m_cf == f && m_cd == d)) begin
            m_found = 1;
            m_sel   = s;
          end
        end
      end
`ifdef HALL_CALL_REDISPATCH_EN
      if (m_cnt == RC - 1) begin
        foreach (m_disp[f, d]) if (m_pend[f][d]) m_disp[f][d] = 0;
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
`endif
      if (m_valid) begin
        if (m_hs) begin
          m_disp[m_floor][m_up] = 1;
          m_ptr   = (2 * m_floor + int'(m_up) + 1) % (2 * NF);
          m_valid = 0;
        end else if (m_clr && m_cf == m_floor && m_cd == int'(m_up)) begin
          m_valid = 0;
        end
      end else if (m_found) begin
        m_valid = 1;
        m_floor = m_sel / 2;
        m_up    = (m_sel % 2) == 1;
      end
      for (int f = 0; f < NF; f++) begin
        if (hall_req_up[f] && f < NF - 1) m_pend[f][1] = 1;
        if (hall_req_down[f] && f > 0)    m_pend[f][0] = 1;
      end
      if (m_clr) begin
        m_pend[m_cf][m_cd] = 0;
        m_disp[m_cf][m_cd] = 0;
      end
    end
  end

  function automatic logic [2*NF+4:0] model_vec();
    logic [NF-1:0] lu, ld;
    for (int f = 0; f < NF; f++) begin
      lu[f] = m_pend[f][1];
      ld[f] = m_pend[f][0];
    end
    return {lu, ld, m_valid, FW'(m_floor), m_up};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hall_req_up      = '0;
    hall_req_down    = '0;
    dispatch_ready   = 1'b0;
    car_arrived      = 1'b0;
    car_floor        = '0;
    car_dir_up_ndown = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic arrive(input int f, input bit up);
    car_arrived      = 1'b1;
    car_floor        = FW'(f);
    car_dir_up_ndown = up;
    tick();
    car_arrived      = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_assert++;
    if ({lamp_up, lamp_down, dispatch_valid, dispatch_floor, dispatch_up_ndown} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0",
               {lamp_up, lamp_down, dispatch_valid, dispatch_floor, dispatch_up_ndown});
    end
  endtask

  task automatic test_single_call();
    do_reset();
    hall_req_up = 7'b0000100;
    tick();
    hall_req_up = '0;
    n_assert++;
    if (lamp_up !== 7'b0000100 || dispatch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_lamp: lamp_up %b valid %b want 0000100 0", lamp_up, dispatch_valid);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      n_assert++;
      if ({dispatch_valid, dispatch_floor, dispatch_up_ndown} !== {1'b1, 3'd2, 1'b1}) begin
        n_fail++;
        $display("FAIL single_offer cyc%0d: got v%b f%0d u%b want v1 f2 u1",
                 i, dispatch_valid, dispatch_floor, dispatch_up_ndown);
      end
      if (i < 5) tick();
    end
    dispatch_ready = 1'b1;
    tick();
    dispatch_ready = 1'b0;
    n_assert++;
    if (dispatch_valid !== 1'b0 || lamp_up !== 7'b0000100) begin
      n_fail++;
      $display("FAIL single_accept: valid %b lamp_up %b want 0 0000100", dispatch_valid, lamp_up);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_assert++;
      if (dispatch_valid !== m_valid) begin
        n_fail++;
        $display("FAIL single_no_reoffer: valid %b want %b", dispatch_valid, m_valid);
      end
    end
    arrive(2, 1'b1);
    n_assert++;
    if (lamp_up !== '0) begin
      n_fail++;
      $display("FAIL single_clear: lamp_up %b want 0", lamp_up);
    end
  endtask

  task automatic test_ignored_slots();
    do_reset();
    hall_req_up   = 7'b1000000;
    hall_req_down = 7'b0000001;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      n_assert++;
      if ({lamp_up, lamp_down, dispatch_valid} !== '0) begin
        n_fail++;
        $display("FAIL ignored_slots cyc%0d: up %b dn %b v %b want all 0", i, lamp_up, lamp_down, dispatch_valid);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    hall_req_down  = 7'b0001000;
    hall_req_up    = 7'b0000010;
    dispatch_ready = 1'b1;
    tick();
    hall_req_down = '0;
    hall_req_up   = '0;
    n_assert++;
    if (lamp_up !== 7'b0000010 || lamp_down !== 7'b0001000 || dispatch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_lamps: up %b dn %b v %b", lamp_up, lamp_down, dispatch_valid);
    end
    tick();
    n_assert++;
    if ({dispatch_valid, dispatch_floor, dispatch_up_ndown} !== {1'b1, 3'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL rr_first: got v%b f%0d u%b want v1 f1 u1", dispatch_valid, dispatch_floor, dispatch_up_ndown);
    end
    tick();
    n_assert++;
    if (dispatch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_gap: valid %b want 0", dispatch_valid);
    end
    tick();
    n_assert++;
    if ({dispatch_valid, dispatch_floor, dispatch_up_ndown} !== {1'b1, 3'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL rr_second: got v%b f%0d u%b want v1 f3 u0", dispatch_valid, dispatch_floor, dispatch_up_ndown);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_assert++;
      if (dispatch_valid !== m_valid || (i == 0 && dispatch_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL rr_no_reoffer cyc%0d: valid %b want %b", i, dispatch_valid, m_valid);
      end
    end
    dispatch_ready = 1'b0;
    arrive(1, 1'b1);
    arrive(3, 1'b0);
  endtask

  task automatic test_withdrawal();
    do_reset();
    hall_req_up = 7'b0010000;
    tick();
    hall_req_up = '0;
    tick();
    tick();
    n_assert++;
    if ({dispatch_valid, dispatch_floor, dispatch_up_ndown} !== {1'b1, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL wd_offer: got v%b f%0d u%b want v1 f4 u1", dispatch_valid, dispatch_floor, dispatch_up_ndown);
    end
    arrive(4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_assert++;
      if (lamp_up !== '0 || dispatch_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL withdrawal cyc%0d: lamp_up %b valid %b want 0 0", i, lamp_up, dispatch_valid);
      end
      tick();
    end
  endtask

  task automatic test_set_clear_collision();
    do_reset();
    hall_req_down    = 7'b0100000;
    car_arrived      = 1'b1;
    car_floor        = 3'd5;
    car_dir_up_ndown = 1'b0;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      n_assert++;
      if (lamp_down !== '0 || dispatch_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL collision cyc%0d: lamp_down %b valid %b want 0 0", i, lamp_down, dispatch_valid);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    hall_req_up = 7'b0000001;
    tick();
    hall_req_up = '0;
    tick();
    n_assert++;
    if ({dispatch_valid, dispatch_floor, dispatch_up_ndown} !== {1'b1, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mid_offer_pre: got v%b f%0d u%b want v1 f0 u1", dispatch_valid, dispatch_floor, dispatch_up_ndown);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_assert++;
    if ({lamp_up, lamp_down, dispatch_valid, dispatch_floor, dispatch_up_ndown} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_offer: got %h want 0",
               {lamp_up, lamp_down, dispatch_valid, dispatch_floor, dispatch_up_ndown});
    end
  endtask

  task automatic test_random();
    logic [2*NF+4:0] got, exp;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int f = 0; f < NF; f++) begin
        hall_req_up[f]   = ($urandom_range(9) == 0);
        hall_req_down[f] = ($urandom_range(9) == 0);
      end
      dispatch_ready   = ($urandom_range(2) == 0);
      car_arrived      = ($urandom_range(2) == 0);
      car_floor        = FW'($urandom_range(7));
      car_dir_up_ndown = 1'($urandom_range(1));
      reset            = ($urandom_range(400) == 0);
      tick();
      got = {lamp_up, lamp_down, dispatch_valid, dispatch_floor, dispatch_up_ndown};
      exp = model_vec();
      n_assert++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %h want %h", c, got, exp);
      end
    end
    idle_inputs();
    reset = 1'b0;
  endtask

`ifdef HALL_CALL_REDISPATCH_EN
  task automatic test_redispatch();
    int  waited;
    bit  seen;
    do_reset();
    hall_req_up = 7'b0000100;
    tick();
    hall_req_up = '0;
    tick();
    dispatch_ready = 1'b1;
    tick();
    dispatch_ready = 1'b0;
    seen   = 0;
    waited = 0;
    while (!seen && waited < RC + 2) begin
      tick();
      waited++;
      if (dispatch_valid === 1'b1) seen = 1;
    end
    n_assert++;
    if (!seen || dispatch_floor !== 3'd2 || dispatch_up_ndown !== 1'b1) begin
      n_fail++;
      $display("FAIL redispatch: seen %0d after %0d cycles f%0d u%b want reoffer f2 u1",
               seen, waited, dispatch_floor, dispatch_up_ndown);
    end
    dispatch_ready = 1'b1;
    tick();
    dispatch_ready = 1'b0;
    arrive(2, 1'b1);
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_call();
    test_ignored_slots();
    test_round_robin();
    test_withdrawal();
    test_set_clear_collision();
    test_reset_mid_offer();
`ifdef HALL_CALL_REDISPATCH_EN
    test_redispatch();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hall_call_manager.md
Name: hall_call_manager

Overview:
- Building-controller-side receiver for the hallway button panels on floors 0..NUM_FLOORS-1.
- Latches each floor's up/down hall call and drives the matching lamp as the acknowledge back to the panel.
- Serializes pending, not-yet-dispatched calls to the car dispatcher over a valid/ready handshake.
- Clears each call when a car arrives at that floor travelling in the call's direction.

Parameters:
- NUM_FLOORS, 7, number of floors; floor indices 0..NUM_FLOORS-1.
- FLOOR_W, 3, width of floor index fields.
- REDISPATCH_CYCLES, 1024, re-offer timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- hall_req_up  in  NUM_FLOORS  bit f: up request from the floor f panel (registered panel output, level).
- hall_req_down  in  NUM_FLOORS  bit f: down request from the floor f panel.
- lamp_up  out  NUM_FLOORS  bit f: up call at floor f pending (acknowledge/illumination).
- lamp_down  out  NUM_FLOORS  bit f: down call at floor f pending.
- dispatch_valid  out  1  call offered to the dispatcher.
- dispatch_floor  out  FLOOR_W  floor of the offered call.
- dispatch_up_ndown  out  1  direction of the offered call; 1 = up.
- dispatch_ready  in  1  dispatcher accepts the offered call.
- car_arrived  in  1  one-cycle pulse: a car has stopped with doors opening.
- car_floor  in  FLOOR_W  floor of the arriving car.
- car_dir_up_ndown  in  1  direction the arriving car will continue in.

Behaviour:
- Reset: lamp_up = 0, lamp_down = 0, dispatch_valid = 0, dispatch_floor = 0, dispatch_up_ndown = 0. All dispatched bits = 0, round-robin pointer = 0, FSM in SEARCH.
- Call slots:
  - slot index = 2*floor + dir, where dir 1 = up.
  - Each slot holds a pending bit (equal to its lamp) and a dispatched bit.
  - Slots for up at floor NUM_FLOORS-1 and down at floor 0 are tied to 0. Requests to those slots are ignored.
- Set rule: a request bit sampled high in cycle N sets pending. The lamp is high from N+1. A request to an already-pending slot has no effect, and its dispatched bit is unchanged.
- Clear rule: car_arrived in cycle N clears pending and dispatched of slot (car_floor, car_dir_up_ndown) from N+1. A car_floor >= NUM_FLOORS is ignored.
- Simultaneous set and clear on the same slot: clear wins; the slot ends cleared.
- FSM SEARCH:
  - Each cycle, select the first slot with pending=1 and dispatched=0, scanning upward from the pointer with wrap-around.
  - A slot being cleared this cycle is not eligible.
  - If a slot is found, register its floor and direction onto the dispatch outputs, set dispatch_valid=1 next cycle, and go to OFFER. Otherwise stay.
- FSM OFFER:
  - Hold dispatch_valid, dispatch_floor and dispatch_up_ndown stable.
  - On dispatch_valid && dispatch_ready: set the slot's dispatched bit, set pointer = slot+1 (wraps 2*NUM_FLOORS-1 to 0), drop valid next cycle, return to SEARCH.
  - Valid is therefore low for at least one cycle between offers.
- Withdrawal: if the offered slot is cleared by car_arrived without ready in the same cycle, dispatch_valid drops next cycle and the FSM returns to SEARCH. Pointer and bits are otherwise unchanged. This is the only case where valid falls without a handshake.
- Ready and clear in the same cycle: the handshake completes and the pointer advances, but clear wins for the slot's bits.
- Latency: request in cycle N gives lamp at N+1, and dispatch_valid at N+2 at the earliest.
- dispatch_ready while valid is low is ignored.
- Reset asserted mid-offer: all state returns to reset values next cycle; the outstanding offer is lost.

Optional Feature:
- Macro: HALL_CALL_REDISPATCH_EN.
- Defined:
  - A free-running counter of width clog2(REDISPATCH_CYCLES) counts 0..REDISPATCH_CYCLES-1 and wraps.
  - On the wrap cycle, every slot with pending=1 and dispatched=1 has dispatched cleared, making it eligible for re-offer.
  - An offer in progress is unaffected. The counter resets to 0.
- Undefined: no counter; dispatched bits are cleared only by car arrival or reset.

Test Plan:
- Reset, then hall_req_up[2]=1 for one cycle. Expect lamp_up[2]=1 next cycle, then dispatch_valid=1 with floor 2, up=1. With ready held low, the outputs stay stable for 5 cycles.
- hall_req_up[6]=1 and hall_req_down[0]=1. Expect no lamp change and dispatch_valid to stay 0.
- Pending down@3 and up@1, pointer 0, ready=1. Expect offers up@1 (slot 3), then down@3 (slot 6), each one cycle apart with valid low in between. Neither is re-offered.
- Offer of up@4 held with ready=0, then car_arrived with floor 4, up. Expect lamp_up[4]=0 and dispatch_valid=0 next cycle; nothing re-offered.
- Same cycle: hall_req_down[5]=1 and car_arrived with floor 5, down. Expect lamp_down[5]=0 and no offer.
- HALL_CALL_REDISPATCH_EN with REDISPATCH_CYCLES=16: dispatch up@2 without a car arriving. Expect up@2 offered again after the counter wraps, within 16 cycles.
